// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core's inst/data sram-like ports, the arbiter
// and the downstream sram-like bus (cache / AXI bridge side).
//
// Handshake rules, shared by every request/response pair in this bundle:
//   *_req is raised by the requester and held, with its address/attributes
//   stable, until the matching *_addr_ok is seen high on a clock edge.
//   *_addr_ok accepts the request in the cycle it is high. *_data_ok marks
//   the single cycle in which read data is valid or a write has completed.
//   The rdata buses carry meaning only in a cycle where *_data_ok is high.
//   bus_addr_ok and bus_data_ok of the same transaction never coincide.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // fetch port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // mem-stage port
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // shared downstream bus
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    // Arbiter view: takes requests from the core, drives the shared bus.
    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    // Environment view: the core ports and the memory side together.
    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter onto one sram-like bus. One transaction in flight at a
// time; data wins ties unless inst has been passed over STARVE_MAX times in
// a row while it was waiting, in which case inst is forced through.
// Internal state is exported on state_o/owner_o/starve_cnt_o for observation.
module mem_bus_arbiter #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave mbus,
    output logic [1:0]       state_o,
    output logic             owner_o,
    output logic [CNT_W-1:0] starve_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [1:0]       SIZE_WORD  = 2'd2;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    logic grant_data;
    logic grant_inst;

    // Grant decision, only acted upon in IDLE: data first unless inst is starved.
    always_comb begin
        grant_data = 1'b0;
        grant_inst = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_data = mbus.data_req &&
                         (!mbus.inst_req || (starve_cnt_q < STARVE_LIM));
            grant_inst = !grant_data && mbus.inst_req;
        end
    end

    // State, owner, starvation counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_DATA;
            starve_cnt_q <= '0;
            req_wr_q     <= 1'b0;
            req_size_q   <= 2'd0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            req_wr_q     <= req_wr_d;
            req_size_q   <= req_size_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

    // Next state: latch the winner in IDLE, then wait for address and response.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        req_wr_d     = req_wr_q;
        req_size_d   = req_size_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    owner_d     = OWN_DATA;
                    req_wr_d    = mbus.data_wr;
                    req_size_d  = mbus.data_size;
                    req_addr_d  = mbus.data_addr;
                    req_wdata_d = mbus.data_wdata;
                    state_d     = ST_ADDR;
                    // Only count a data grant as "starving" when inst was actually waiting.
                    if (mbus.inst_req) begin
                        if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (grant_inst) begin
                    // Fetch port is read-only, word sized.
                    owner_d      = OWN_INST;
                    req_wr_d     = 1'b0;
                    req_size_d   = SIZE_WORD;
                    req_addr_d   = mbus.inst_addr;
                    req_wdata_d  = '0;
                    state_d      = ST_ADDR;
                    starve_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                if (mbus.bus_addr_ok) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mbus.bus_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus drive and per-port handshake pulses routed to the current owner.
    always_comb begin
        mbus.bus_req      = 1'b0;
        mbus.inst_addr_ok = 1'b0;
        mbus.data_addr_ok = 1'b0;
        mbus.inst_data_ok = 1'b0;
        mbus.data_data_ok = 1'b0;

        if (state_q == ST_ADDR) begin
            mbus.bus_req      = 1'b1;
            mbus.inst_addr_ok = mbus.bus_addr_ok && (owner_q == OWN_INST);
            mbus.data_addr_ok = mbus.bus_addr_ok && (owner_q == OWN_DATA);
        end

        // A bus_data_ok seen in any other state is stray and dropped here.
        if (state_q == ST_RESP) begin
            mbus.inst_data_ok = mbus.bus_data_ok && (owner_q == OWN_INST);
            mbus.data_data_ok = mbus.bus_data_ok && (owner_q == OWN_DATA);
        end
    end

    // Request attributes come only from the latched copy, never from live inputs,
    // so they stay stable however long bus_addr_ok is withheld.
    assign mbus.bus_wr    = req_wr_q;
    assign mbus.bus_size  = req_size_q;
    assign mbus.bus_addr  = req_addr_q;
    assign mbus.bus_wdata = req_wdata_q;

    // Read data passes straight through; *_data_ok alone says when it is valid.
    assign mbus.inst_rdata = mbus.bus_rdata;
    assign mbus.data_rdata = mbus.bus_rdata;

    assign state_o      = state_q;
    assign owner_o      = owner_q;
    assign starve_cnt_o = starve_cnt_q;

endmodule
